// File: rtl/pipeline_stage_fifo.sv
// Elastic DEPTH-entry pipeline stage with stall/done handshake, head hold and synchronous flush.
// Optional zero-latency pass-through when empty: define PIPELINE_STAGE_FIFO_BYPASS_EN.
module pipeline_stage_fifo #(
    parameter int PAYLOAD_WIDTH = 96,
    parameter int DEPTH         = 2,
    localparam int COUNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     stall_prev,
    input  logic                     prev_done,
    input  logic [PAYLOAD_WIDTH-1:0] payload_in,
    input  logic                     next_stall,
    output logic                     done_next,
    output logic [PAYLOAD_WIDTH-1:0] payload_out,
    input  logic                     hold,
    input  logic                     flush,
    output logic [COUNT_WIDTH-1:0]   occupancy
);

    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(DEPTH);
    localparam logic [COUNT_WIDTH-1:0] ZERO_COUNT = {COUNT_WIDTH{1'b0}};
    localparam logic [COUNT_WIDTH-1:0] ONE_COUNT  = COUNT_WIDTH'(1);
    localparam logic [PTR_WIDTH-1:0]   LAST_PTR   = PTR_WIDTH'(DEPTH - 1);
    localparam logic [PTR_WIDTH-1:0]   ZERO_PTR   = {PTR_WIDTH{1'b0}};
    localparam logic [PTR_WIDTH-1:0]   ONE_PTR    = PTR_WIDTH'(1);

    logic [PAYLOAD_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_WIDTH-1:0]     wr_ptr_r;
    logic [PTR_WIDTH-1:0]     rd_ptr_r;
    logic [COUNT_WIDTH-1:0]   count_r;

    logic empty_s;
    logic bypass_s;
    logic bypass_take_s;
    logic transfer_prev_s;
    logic transfer_next_s;
    logic write_en_s;
    logic read_en_s;

    // Wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] ptr);
        return (ptr == LAST_PTR) ? ZERO_PTR : ptr + ONE_PTR;
    endfunction

    // Handshake decode; stall_prev sees next_stall only through transfer_next_s.
    always_comb begin
        empty_s = (count_r == ZERO_COUNT);
`ifdef PIPELINE_STAGE_FIFO_BYPASS_EN
        bypass_s = empty_s && prev_done && !hold && !flush && !rst;
`else
        bypass_s = 1'b0;
`endif
        done_next       = !rst && !flush && !hold && (!empty_s || bypass_s);
        payload_out     = bypass_s ? payload_in : mem_r[rd_ptr_r];
        transfer_next_s = done_next && !next_stall;
        stall_prev      = rst || flush || ((count_r == FULL_COUNT) && !transfer_next_s);
        transfer_prev_s = prev_done && !stall_prev;
        // A taken bypass consumes the input directly, so neither side touches storage.
        bypass_take_s   = bypass_s && !next_stall;
        write_en_s      = transfer_prev_s && !bypass_take_s;
        read_en_s       = transfer_next_s && !bypass_take_s;
        occupancy       = count_r;
    end

    // Pointer and occupancy state; reset and flush discard every entry identically.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= ZERO_PTR;
            rd_ptr_r <= ZERO_PTR;
            count_r  <= ZERO_COUNT;
        end else begin
            if (write_en_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (read_en_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({write_en_s, read_en_s})
                2'b10:   count_r <= count_r + ONE_COUNT;
                2'b01:   count_r <= count_r - ONE_COUNT;
                default: count_r <= count_r;
            endcase
        end
    end

    // Payload storage is left unreset; stale slots are never presented as valid.
    always_ff @(posedge clk) begin
        if (write_en_s) begin
            mem_r[wr_ptr_r] <= payload_in;
        end
    end

endmodule

// File: tb/tb_pipeline_stage_fifo.sv
// Scoreboard bench for pipeline_stage_fifo: DEPTH=2 and DEPTH=3 instances, each with
// its own stimulus and an independent queue model checked every cycle.
module tb_pipeline_stage_fifo;

    localparam int PW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    rst_v, pd_v, ns_v, hold_v, fl_v, done_v, stall_v;
    logic [PW-1:0] pin_v  [2];
    logic [PW-1:0] pout_v [2];
    logic [1:0]    occ2, occ3;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [PW-1:0] sb_q [2][$];
    int            emitted [2];
    logic          acc [2];
    int            depth_of [2];

    pipeline_stage_fifo #(.PAYLOAD_WIDTH(PW), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst_v[0]), .stall_prev(stall_v[0]), .prev_done(pd_v[0]),
        .payload_in(pin_v[0]), .next_stall(ns_v[0]), .done_next(done_v[0]),
        .payload_out(pout_v[0]), .hold(hold_v[0]), .flush(fl_v[0]), .occupancy(occ2)
    );

    pipeline_stage_fifo #(.PAYLOAD_WIDTH(PW), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst_v[1]), .stall_prev(stall_v[1]), .prev_done(pd_v[1]),
        .payload_in(pin_v[1]), .next_stall(ns_v[1]), .done_next(done_v[1]),
        .payload_out(pout_v[1]), .hold(hold_v[1]), .flush(fl_v[1]), .occupancy(occ3)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] occ_of(input int k);
        return (k == 0) ? {30'd0, occ2} : {30'd0, occ3};
    endfunction

    // One clock cycle: predict from the model, compare at negedge, advance the model.
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            int            cnt;
            logic          byp, edone, etn, estall, etp;
            logic [PW-1:0] ehead;
            cnt = sb_q[k].size();
            byp = 1'b0;
`ifdef PIPELINE_STAGE_FIFO_BYPASS_EN
            byp = (cnt == 0) && pd_v[k] && !hold_v[k] && !fl_v[k] && !rst_v[k];
`endif
            edone  = !rst_v[k] && !fl_v[k] && !hold_v[k] && ((cnt != 0) || byp);
            etn    = edone && !ns_v[k];
            estall = rst_v[k] || fl_v[k] || ((cnt == depth_of[k]) && !etn);
            etp    = pd_v[k] && !estall;
            check_val($sformatf("occ%0d", k), occ_of(k), cnt);
            check_val($sformatf("done%0d", k), {31'd0, done_v[k]}, {31'd0, edone});
            check_val($sformatf("stall%0d", k), {31'd0, stall_v[k]}, {31'd0, estall});
            if (edone) begin
                ehead = byp ? pin_v[k] : sb_q[k][0];
                check_val($sformatf("payload%0d", k), {16'd0, pout_v[k]}, {16'd0, ehead});
            end
            if (rst_v[k] || fl_v[k]) begin
                sb_q[k].delete();
            end else if (byp && !ns_v[k]) begin
                emitted[k]++;
            end else begin
                if (etn) begin
                    void'(sb_q[k].pop_front());
                    emitted[k]++;
                end
                if (etp) sb_q[k].push_back(pin_v[k]);
            end
            acc[k] = etp;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int k);
        pd_v[k] = 1'b0; ns_v[k] = 1'b0; hold_v[k] = 1'b0; fl_v[k] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (sb_q[k].size() == 0) break;
            step();
        end
        step();
    endtask

    initial begin
        int base, i, maxocc;
        depth_of[0] = 2; depth_of[1] = 3;
        emitted[0] = 0; emitted[1] = 0;
        rst_v = 2'b11; pd_v = 2'b00; ns_v = 2'b00; hold_v = 2'b00; fl_v = 2'b00;
        pin_v[0] = 16'h0; pin_v[1] = 16'h0;
        @(posedge clk);
        #1;
        step();
        step();
        check_val("rst_stall", {31'd0, stall_v[0]}, 32'd1);
        check_val("rst_done", {31'd0, done_v[0]}, 32'd0);
        rst_v = 2'b00;
        step();

        // Fill DEPTH=2 while downstream stalls; third payload must be refused.
        base = emitted[0];
        ns_v[0] = 1'b1; pd_v[0] = 1'b1;
        pin_v[0] = 16'h000A; step();
        pin_v[0] = 16'h000B; step();
        pin_v[0] = 16'h000C;
        #1;
        check_val("fill_occ", {30'd0, occ2}, 32'd2);
        check_val("fill_stall_c", {31'd0, stall_v[0]}, 32'd1);
        step();
        // Release: head leaves and 0xC enters the full buffer in the same cycle.
        ns_v[0] = 1'b0;
        step();
        check_val("pass_occ", {30'd0, occ2}, 32'd2);
        drain(0);
        check_val("pass_emitted", emitted[0] - base, 32'd3);

        // Pointer wrap on DEPTH=3 with next_stall toggling every cycle.
        base = emitted[1]; i = 0; maxocc = 0;
        for (int cyc = 0; cyc < 100 && i < 10; cyc++) begin
            pd_v[1] = 1'b1;
            pin_v[1] = 16'h0040 + 16'(i);
            ns_v[1] = cyc[0];
            step();
            if (acc[1]) i++;
            if (int'(occ3) > maxocc) maxocc = int'(occ3);
        end
        drain(1);
        check_val("wrap_sent", i, 32'd10);
        check_val("wrap_emitted", emitted[1] - base, 32'd10);
        check_val("wrap_maxocc", {31'd0, maxocc <= 3}, 32'd1);

        // Hold freezes the head while upstream fills to DEPTH.
        ns_v[0] = 1'b0; pd_v[0] = 1'b1; pin_v[0] = 16'h0005; step();
        hold_v[0] = 1'b1; pin_v[0] = 16'h0006; step();
        pin_v[0] = 16'h0007; step();
        step();
        check_val("hold_occ", {30'd0, occ2}, 32'd2);
        check_val("hold_done", {31'd0, done_v[0]}, 32'd0);
        hold_v[0] = 1'b0; pd_v[0] = 1'b0;
        check_val("hold_head", {16'd0, pout_v[0]}, 32'h5);
        step();
        drain(0);

        // Flush, then reset, with two entries stored and an offered input.
        for (int r = 0; r < 2; r++) begin
            ns_v[0] = 1'b1; pd_v[0] = 1'b1;
            pin_v[0] = 16'h0021; step();
            pin_v[0] = 16'h0022; step();
            pin_v[0] = 16'h0023;
            if (r == 0) fl_v[0] = 1'b1; else rst_v[0] = 1'b1;
            #1;
            check_val($sformatf("discard_stall%0d", r), {31'd0, stall_v[0]}, 32'd1);
            step();
            check_val($sformatf("discard_occ%0d", r), {30'd0, occ2}, 32'd0);
            fl_v[0] = 1'b0; rst_v[0] = 1'b0; pd_v[0] = 1'b0; ns_v[0] = 1'b0;
            #1;
            check_val($sformatf("discard_done%0d", r), {31'd0, done_v[0]}, 32'd0);
            step();
        end

        // Empty buffer offered 0x7 with downstream ready.
        ns_v[0] = 1'b0; hold_v[0] = 1'b0; pd_v[0] = 1'b1; pin_v[0] = 16'h0007;
        #1;
`ifdef PIPELINE_STAGE_FIFO_BYPASS_EN
        check_val("byp_done", {31'd0, done_v[0]}, 32'd1);
        check_val("byp_payload", {16'd0, pout_v[0]}, 32'h7);
        step();
        pd_v[0] = 1'b0;
        #1;
        check_val("byp_occ", {30'd0, occ2}, 32'd0);
`else
        check_val("nobyp_done0", {31'd0, done_v[0]}, 32'd0);
        step();
        pd_v[0] = 1'b0;
        #1;
        check_val("nobyp_done1", {31'd0, done_v[0]}, 32'd1);
        check_val("nobyp_payload", {16'd0, pout_v[0]}, 32'h7);
        check_val("nobyp_occ", {30'd0, occ2}, 32'd1);
`endif
        drain(0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
